// File: rtl/fib_seq_display_core.sv
// fib_seq_display_core
// Parametrised Fibonacci sequence engine for board-level demos. A prescaler
// paces free-running advances, a synchronised button single-steps while
// paused, seeds can be loaded at any time and overflow either wraps to the
// seeds or halts the sequence. The current term is presented as a packed
// nibble bus for sev_seg_controller, with unused slots blanked (4'hF).
//
// Optional feature: define FIB_DEBOUNCE_EN to insert a DEB_CYCLES stability
// filter between the button synchroniser and the edge detector.

module fib_seq_display_core #(
    parameter int WIDTH      = 8,
    parameter int DIV        = 20_000_000,
    parameter int DIGITS     = 8,
    parameter int IDX_W      = 8,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  step_btn,
    input  logic                  halt_on_ovf,
    input  logic                  load,
    input  logic [WIDTH-1:0]      seed_a,
    input  logic [WIDTH-1:0]      seed_b,
    output logic [WIDTH-1:0]      value,
    output logic [IDX_W-1:0]      index,
    output logic                  ovf,
    output logic                  halted,
    output logic [4*DIGITS-1:0]   digits
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam int NIB = (WIDTH + 3) / 4;

    typedef enum logic [1:0] {
        S_PAUSE = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    // Reject parameter combinations the datapath cannot represent
    if (WIDTH < 2 || WIDTH > 32 || DIV < 2 || DIGITS < NIB || IDX_W < 1 || DEB_CYCLES < 1) begin : g_param_err
        $error("fib_seq_display_core: illegal parameter combination");
    end

    state_t             state_r, state_n;
    logic [WIDTH-1:0]   a_r, a_n, b_r, b_n;
    logic [IDX_W-1:0]   index_r, index_n;
    logic               ovf_r, ovf_n;
    logic               halted_r, halted_n;
    logic [CNT_W-1:0]   cnt_r, cnt_n;
    logic [WIDTH:0]     sum_s;
    logic               tick_s;
    logic               adv_s;

    logic               sync1_r, sync2_r;
    logic               btn_level_s;
    logic               btn_prev_r;
    logic               step_p_s;

    // Two-flop synchroniser for the raw, asynchronous step button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= step_btn;
            sync2_r <= sync1_r;
        end
    end

`ifdef FIB_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    logic               deb_level_r;
    logic [DEB_W-1:0]   deb_cnt_r;

    // Accept a new button level only after it has differed for DEB_CYCLES cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_level_r <= 1'b0;
            deb_cnt_r   <= '0;
        end else if (sync2_r == deb_level_r) begin
            deb_cnt_r   <= '0;
        end else if (deb_cnt_r == DEB_W'(DEB_CYCLES - 1)) begin
            deb_level_r <= sync2_r;
            deb_cnt_r   <= '0;
        end else begin
            deb_cnt_r   <= deb_cnt_r + DEB_W'(1);
        end
    end

    assign btn_level_s = deb_level_r;
`else
    assign btn_level_s = sync2_r;
`endif

    // Previous button level for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev_r <= 1'b0;
        end else begin
            btn_prev_r <= btn_level_s;
        end
    end

    assign step_p_s = btn_level_s & ~btn_prev_r;

    // Next-state logic: mode transitions, prescaler, advance, load override
    always_comb begin
        state_n  = state_r;
        a_n      = a_r;
        b_n      = b_r;
        index_n  = index_r;
        ovf_n    = ovf_r;
        cnt_n    = '0;
        sum_s    = {1'b0, a_r} + {1'b0, b_r};
        tick_s   = (state_r == S_RUN) && (cnt_r == CNT_MAX);
        adv_s    = ((state_r == S_RUN) && tick_s) || ((state_r == S_PAUSE) && step_p_s);

        case (state_r)
            S_PAUSE: begin
                if (run) begin
                    state_n = S_RUN;
                end else begin
                    state_n = S_PAUSE;
                end
            end
            S_RUN: begin
                if (run) begin
                    state_n = S_RUN;
                end else begin
                    state_n = S_PAUSE;
                end
            end
            S_HALT: begin
                state_n = S_HALT;
            end
            default: begin
                state_n = S_PAUSE;
            end
        endcase

        // Prescaler runs only while staying in RUN; it restarts from zero after a tick
        if ((state_r == S_RUN) && run && !tick_s) begin
            cnt_n = cnt_r + CNT_W'(1);
        end else begin
            cnt_n = '0;
        end

        if (load) begin
            a_n     = seed_a;
            b_n     = seed_b;
            index_n = '0;
            ovf_n   = 1'b0;
            cnt_n   = '0;
            state_n = run ? S_RUN : S_PAUSE;
        end else if (adv_s) begin
            if (!sum_s[WIDTH]) begin
                a_n     = b_r;
                b_n     = sum_s[WIDTH-1:0];
                index_n = index_r + IDX_W'(1);
            end else if (!halt_on_ovf) begin
                a_n     = seed_a;
                b_n     = seed_b;
                index_n = '0;
                ovf_n   = 1'b1;
            end else begin
                // Show the last representable term and freeze there
                a_n     = b_r;
                b_n     = b_r;
                index_n = index_r + IDX_W'(1);
                ovf_n   = 1'b1;
                state_n = S_HALT;
            end
        end else begin
            a_n = a_r;
        end

        halted_n = (state_n == S_HALT);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= S_PAUSE;
            a_r      <= '0;
            b_r      <= WIDTH'(1);
            index_r  <= '0;
            ovf_r    <= 1'b0;
            halted_r <= 1'b0;
            cnt_r    <= '0;
        end else begin
            state_r  <= state_n;
            a_r      <= a_n;
            b_r      <= b_n;
            index_r  <= index_n;
            ovf_r    <= ovf_n;
            halted_r <= halted_n;
            cnt_r    <= cnt_n;
        end
    end

    assign value  = a_r;
    assign index  = index_r;
    assign ovf    = ovf_r;
    assign halted = halted_r;

    logic [4*NIB-1:0] value_pad_s;

    // Zero-extend the term to a whole number of nibbles
    always_comb begin
        value_pad_s             = '0;
        value_pad_s[WIDTH-1:0]  = a_r;
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        if (k < NIB) begin : g_hex
            assign digits[4*k +: 4] = value_pad_s[4*k +: 4];
        end else begin : g_blank
            assign digits[4*k +: 4] = 4'hF;
        end
    end

endmodule

// File: tb/tb_fib_seq_display_core.sv
// Directed bench for fib_seq_display_core (WIDTH=8, DIV=4, DIGITS=8).
// Expected terms come from a small reference model and pass through a
// scoreboard queue; each comparison is an immediate assertion.

module tb_fib_seq_display_core;

    localparam int W   = 8;
    localparam int DV  = 4;
    localparam int DG  = 8;
    localparam int IW  = 8;
    localparam int DEB = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic              step_btn;
    logic              halt_on_ovf;
    logic              load;
    logic [W-1:0]      seed_a;
    logic [W-1:0]      seed_b;
    logic [W-1:0]      value;
    logic [IW-1:0]     index;
    logic              ovf;
    logic              halted;
    logic [4*DG-1:0]   digits;

    fib_seq_display_core #(
        .WIDTH(W), .DIV(DV), .DIGITS(DG), .IDX_W(IW), .DEB_CYCLES(DEB)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .step_btn(step_btn),
        .halt_on_ovf(halt_on_ovf), .load(load), .seed_a(seed_a), .seed_b(seed_b),
        .value(value), .index(index), .ovf(ovf), .halted(halted), .digits(digits)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    int m_a, m_b, m_idx, m_ovf, m_halt;
    int fib_tab[12] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model of one advance
    task automatic model_adv(input int sa, input int sb, input int hov);
        int s;
        if (m_halt == 0) begin
            s = m_a + m_b;
            if (s < (1 << W)) begin
                m_a = m_b; m_b = s; m_idx = (m_idx + 1) % (1 << IW);
            end else if (hov == 0) begin
                m_a = sa; m_b = sb; m_idx = 0; m_ovf = 1;
            end else begin
                m_a = m_b; m_idx = (m_idx + 1) % (1 << IW); m_ovf = 1; m_halt = 1;
            end
        end
    endtask

    task automatic model_load(input int sa, input int sb);
        m_a = sa; m_b = sb; m_idx = 0; m_ovf = 0; m_halt = 0;
    endtask

    task automatic push_exp();
        exp_q.push_back(W'(m_a));
    endtask

    task automatic sb_check(input string tag);
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check(tag, value, e);
    endtask

    task automatic press();
        step_btn = 1'b1;
        repeat (4) @(posedge clk);
        step_btn = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_load(input int sa, input int sb);
        seed_a = W'(sa);
        seed_b = W'(sb);
        load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        model_load(sa, sb);
    endtask

    // Count clock edges until value changes, bounded at 50
    task automatic wait_change(output int n);
        logic [W-1:0] prev;
        prev = value;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (value !== prev) break;
        end
    endtask

    initial begin
        int n;
        int nadv;
        rst = 1'b1; run = 1'b0; step_btn = 1'b0; halt_on_ovf = 1'b0;
        load = 1'b0; seed_a = '0; seed_b = '0;
        model_load(0, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_value", value, 0);
        check("rst_index", index, 0);
        check("rst_ovf", ovf, 0);
        check("rst_halted", halted, 0);
        check("rst_digits", digits, 32'hFFFF_FF00);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_value", value, 0);

        // Twelve single steps from reset
        for (int i = 0; i < 12; i++) begin
            model_adv(0, 1, 0);
            push_exp();
            press();
            sb_check("step_seq");
            check("step_tab", value, fib_tab[i]);
        end
        check("step_index", index, 12);
        check("step_digits", digits, 32'hFFFF_FF90);

        // Halting overflow
        halt_on_ovf = 1'b1;
        model_adv(0, 1, 1);
        push_exp();
        press();
        sb_check("halt_value_sb");
        check("halt_value", value, 233);
        check("halt_ovf", ovf, 1);
        check("halt_halted", halted, 1);
        check("halt_index", index, 13);
        press();
        run = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        run = 1'b0;
        check("halt_hold_value", value, 233);
        check("halt_hold_halted", halted, 1);
        check("halt_hold_index", index, 13);

        // Load leaves HALT; wrapping overflow returns to seeds
        halt_on_ovf = 1'b0;
        do_load(0, 1);
        check("load_halted", halted, 0);
        check("load_ovf", ovf, 0);
        check("load_index", index, 0);
        check("load_value", value, 0);
        for (int i = 0; i < 12; i++) begin
            model_adv(0, 1, 0);
            push_exp();
            press();
            sb_check("wrap_pre_seq");
        end
        model_adv(0, 1, 0);
        push_exp();
        press();
        sb_check("wrap_value");
        check("wrap_index", index, 0);
        check("wrap_ovf", ovf, 1);
        check("wrap_halted", halted, 0);
        model_adv(0, 1, 0);
        push_exp();
        press();
        sb_check("wrap_next");
        check("wrap_next_const", value, 1);
        check("wrap_ovf_sticky", ovf, 1);

        // Free-run pacing: one edge to enter RUN, then DIV cycles per advance
        do_load(1, 2);
        run = 1'b1;
        wait_change(n);
        check("run_first_lat", n, DV + 1);
        model_adv(1, 2, 0); push_exp(); sb_check("run_v1");
        for (int i = 0; i < 2; i++) begin
            wait_change(n);
            check("run_period", n, DV);
            model_adv(1, 2, 0); push_exp(); sb_check("run_vn");
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        run = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("pause_hold", value, m_a);
        run = 1'b1;
        wait_change(n);
        check("resume_lat", n, DV + 1);
        model_adv(1, 2, 0); push_exp(); sb_check("resume_v");

        // Load in the same cycle as a tick
        repeat (3) @(posedge clk);
        @(negedge clk);
        seed_a = 8'd5;
        seed_b = 8'd7;
        load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        model_load(5, 7);
        check("ldtick_value", value, 5);
        check("ldtick_index", index, 0);
        check("ldtick_ovf", ovf, 0);
        wait_change(n);
        check("ldtick_lat1", n, DV);
        model_adv(5, 7, 0); push_exp(); sb_check("ldtick_v7");
        wait_change(n);
        check("ldtick_lat2", n, DV);
        model_adv(5, 7, 0); push_exp(); sb_check("ldtick_v12");
        check("ldtick_v12_const", value, 12);
        run = 1'b0;
        repeat (2) @(negedge clk);

        // Short glitches then a long press on the step button
`ifdef FIB_DEBOUNCE_EN
        nadv = 1;
`else
        nadv = 4;
`endif
        for (int g = 0; g < 3; g++) begin
            step_btn = 1'b1;
            repeat (5) @(posedge clk);
            step_btn = 1'b0;
            repeat (5) @(posedge clk);
        end
        step_btn = 1'b1;
        repeat (20) @(posedge clk);
        step_btn = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < nadv; k++) model_adv(5, 7, 0);
        push_exp();
        sb_check("glitch_value");
        check("glitch_index", index, m_idx);

        // Reset asserted mid-run clears everything at once
        run = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_value", value, 0);
        check("midrst_index", index, 0);
        check("midrst_ovf", ovf, 0);
        check("midrst_halted", halted, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
